// File: rtl/ext_ctrl_gen_if.sv
// Gigatron bus side of the expansion ctrl decoder: ctrl strobe, live address,
// SRAM high-address output and readback override.
interface ext_ctrl_gen_if #(
    parameter int BANK0_BITS = 4
);
    logic                  CTRL_VALID;
    logic [15:0]           CTRL_ADDR;
    logic [15:0]           GA;
    logic                  NGOE;
    logic [BANK0_BITS-1:0] RA_HI;
    logic                  RD_HIT;
    logic [7:0]            RD_DATA;

    modport master (
        output CTRL_VALID, CTRL_ADDR, GA, NGOE,
        input  RA_HI, RD_HIT, RD_DATA
    );

    modport slave (
        input  CTRL_VALID, CTRL_ADDR, GA, NGOE,
        output RA_HI, RD_HIT, RD_DATA
    );
endinterface

// File: rtl/ext_ctrl_gen.sv
// Gigatron expansion ctrl-code decoder: banking, bit-bang SPI and an auto SPI byte shifter.
// Define CTRL_ZPBANK_EN to let ctrl bit 5 swap banking of page 0x0080-0x00FF.
module ext_ctrl_gen #(
    parameter int NSS        = 2,
    parameter int BANK0_BITS = 4,
    parameter int SPI_DIV    = 2
) (
    input  logic           CLK,
    input  logic           RESET,
    ext_ctrl_gen_if.slave  bus,
    input  logic           MISO,
    input  logic [1:0]     XIN,
    output logic           SCK,
    output logic           MOSI,
    output logic [NSS-1:0] SS_N,
    output logic           BUSY,
    output logic           DONE
);
    localparam int DIV_W = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SPI_DIV - 1);

    // LOW shares SETUP: after a falling edge the next bit is set up for SPI_DIV cycles.
    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_HIGH} state_t;

    state_t                state_reg,  state_next;
    logic [1:0]            bank_reg,   bank_next;
    logic                  nzpbank_reg, nzpbank_next;
    logic [BANK0_BITS-1:0] bank0r_reg, bank0r_next;
    logic [BANK0_BITS-1:0] bank0w_reg, bank0w_next;
    logic [NSS-1:0]        ss_n_reg,   ss_n_next;
    logic                  sclk_reg,   sclk_next;
    logic                  sck_reg,    sck_next;
    logic                  mosi_reg,   mosi_next;
    logic                  busy_reg,   busy_next;
    logic                  done_reg,   done_next;
    logic                  ovr_reg,    ovr_next;
    logic [7:0]            rxbyte_reg, rxbyte_next;
    logic [7:0]            shreg_reg,  shreg_next;
    logic [7:0]            rx_reg,     rx_next;
    logic [2:0]            bit_cnt_reg, bit_cnt_next;
    logic [DIV_W-1:0]      div_cnt_reg, div_cnt_next;

    logic [15:0] a;
    logic        is_ext;
    logic        start_req;
    logic        start_ok;
    logic        zpwin;
    logic        bankenable;
    logic        sel_stat;
    logic        sel_bank0;
    logic        sel_rx;
    logic        rd_hit;

    assign a         = bus.CTRL_ADDR;
    assign is_ext    = (a[3:2] == 2'b00);
    assign start_req = bus.CTRL_VALID && is_ext && (a[7:4] == 4'hE);
    // The DONE cycle still counts as busy so a back-to-back start is flagged, not lost.
    assign start_ok  = start_req && !busy_reg && !done_reg;

    assign zpwin      = !nzpbank_reg && (bus.GA[14:7] == 8'h01);
    assign bankenable = bus.GA[15] ^ zpwin;

    always_comb begin
        bus.RA_HI = '0;
        if (bankenable) begin
            if (bank_reg != 2'b00)
                bus.RA_HI = BANK0_BITS'(bank_reg);
            else if (!bus.NGOE)
                bus.RA_HI = bank0r_reg;
            else
                bus.RA_HI = bank0w_reg;
        end
    end

    assign sel_stat  = (bus.GA == 16'h0000);
    assign sel_bank0 = (bus.GA == 16'h0080);
    assign sel_rx    = (bus.GA == 16'h0081);
    assign rd_hit    = sclk_reg && (sel_stat || sel_bank0 || sel_rx);

    always_comb begin
        bus.RD_DATA = 8'h00;
        if (rd_hit) begin
            if (sel_stat)
                bus.RD_DATA = {bank_reg, 1'b0, XIN, busy_reg, ovr_reg, MISO};
            else if (sel_bank0)
                bus.RD_DATA = {4'(bank0w_reg), 4'(bank0r_reg)};
            else
                bus.RD_DATA = rxbyte_reg;
        end
    end
    assign bus.RD_HIT = rd_hit;

    always_comb begin
        state_next   = state_reg;
        bank_next    = bank_reg;
        nzpbank_next = nzpbank_reg;
        bank0r_next  = bank0r_reg;
        bank0w_next  = bank0w_reg;
        ss_n_next    = ss_n_reg;
        sclk_next    = sclk_reg;
        sck_next     = sck_reg;
        mosi_next    = mosi_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        ovr_next     = ovr_reg;
        rxbyte_next  = rxbyte_reg;
        shreg_next   = shreg_reg;
        rx_next      = rx_reg;
        bit_cnt_next = bit_cnt_reg;
        div_cnt_next = div_cnt_reg;

        if (bus.CTRL_VALID) begin
            if (a[1:0] == 2'b11) begin
                bank0r_next = '0;
                bank0w_next = '0;
            end
            if (!is_ext) begin
                bank_next      = a[7:6];
`ifdef CTRL_ZPBANK_EN
                nzpbank_next   = a[5];
`endif
                ss_n_next[1:0] = a[3:2];
                sclk_next      = a[0];
                // Bit-bang writes would corrupt a running auto transfer.
                if (!busy_reg) begin
                    mosi_next = a[15];
                    sck_next  = a[0] ~^ a[4];
                end
            end else begin
                case (a[7:4])
                    4'hF: begin
                        bank0r_next = a[8 +: BANK0_BITS];
                        bank0w_next = a[12 +: BANK0_BITS];
                    end
                    4'hD:    ss_n_next = a[8 +: NSS];
                    default: ;
                endcase
            end
        end

        // A rejected start in the same cycle as an RX read leaves OVR set.
        if (rd_hit && sel_rx)
            ovr_next = 1'b0;
        if (start_req && !start_ok)
            ovr_next = 1'b1;

        case (state_reg)
            ST_IDLE: begin
                if (start_ok) begin
                    shreg_next   = a[15:8];
                    mosi_next    = a[15];
                    sck_next     = 1'b0;
                    busy_next    = 1'b1;
                    bit_cnt_next = 3'd0;
                    div_cnt_next = '0;
                    state_next   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (div_cnt_reg == DIV_LAST) begin
                    div_cnt_next = '0;
                    sck_next     = 1'b1;
                    rx_next      = {rx_reg[6:0], MISO};
                    state_next   = ST_HIGH;
                end else begin
                    div_cnt_next = div_cnt_reg + DIV_W'(1);
                end
            end
            ST_HIGH: begin
                if (div_cnt_reg == DIV_LAST) begin
                    div_cnt_next = '0;
                    sck_next     = 1'b0;
                    shreg_next   = {shreg_reg[6:0], 1'b0};
                    if (bit_cnt_reg == 3'd7) begin
                        rxbyte_next = rx_reg;
                        busy_next   = 1'b0;
                        done_next   = 1'b1;
                        state_next  = ST_IDLE;
                    end else begin
                        mosi_next    = shreg_reg[6];
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        state_next   = ST_SETUP;
                    end
                end else begin
                    div_cnt_next = div_cnt_reg + DIV_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg   <= ST_IDLE;
            bank_reg    <= 2'b00;
            nzpbank_reg <= 1'b1;
            bank0r_reg  <= '0;
            bank0w_reg  <= '0;
            ss_n_reg    <= '1;
            sclk_reg    <= 1'b0;
            sck_reg     <= 1'b0;
            mosi_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            ovr_reg     <= 1'b0;
            rxbyte_reg  <= 8'h00;
            shreg_reg   <= 8'h00;
            rx_reg      <= 8'h00;
            bit_cnt_reg <= 3'd0;
            div_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            bank_reg    <= bank_next;
            nzpbank_reg <= nzpbank_next;
            bank0r_reg  <= bank0r_next;
            bank0w_reg  <= bank0w_next;
            ss_n_reg    <= ss_n_next;
            sclk_reg    <= sclk_next;
            sck_reg     <= sck_next;
            mosi_reg    <= mosi_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            ovr_reg     <= ovr_next;
            rxbyte_reg  <= rxbyte_next;
            shreg_reg   <= shreg_next;
            rx_reg      <= rx_next;
            bit_cnt_reg <= bit_cnt_next;
            div_cnt_reg <= div_cnt_next;
        end
    end

    assign SCK  = sck_reg;
    assign MOSI = mosi_reg;
    assign SS_N = ss_n_reg;
    assign BUSY = busy_reg;
    assign DONE = done_reg;
endmodule

// File: tb/tb_ext_ctrl_gen.sv
// Scoreboard bench for ext_ctrl_gen: a time-based reference model queues expected
// outputs per cycle, a negedge monitor pops and compares them. MISO is looped to MOSI.
module tb_ext_ctrl_gen;
    localparam int NSS = 2;
    localparam int B0  = 4;
    localparam int DIV = 2;
    localparam int T   = 16 * DIV;

    logic           CLK = 1'b0;
    logic           RESET;
    logic           MISO;
    logic [1:0]     XIN;
    logic           SCK, MOSI, BUSY, DONE;
    logic [NSS-1:0] SS_N;

    ext_ctrl_gen_if #(.BANK0_BITS(B0)) bus();

    assign MISO = MOSI;

    ext_ctrl_gen #(.NSS(NSS), .BANK0_BITS(B0), .SPI_DIV(DIV)) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus), .MISO(MISO), .XIN(XIN),
        .SCK(SCK), .MOSI(MOSI), .SS_N(SS_N), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef enum int {K_RAHI, K_HIT, K_DATA, K_BUSY, K_SCK, K_MOSI, K_SSN, K_DONE} kind_t;
    typedef struct {
        int          cyc;
        kind_t       kind;
        logic [15:0] exp;
        string       name;
    } chk_t;

    chk_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Monitor: compares everything scheduled for the current cycle.
    always @(negedge CLK) begin
        chk_t        c;
        logic [15:0] act;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            c = exp_q.pop_front();
            case (c.kind)
                K_RAHI:  act = 16'(bus.RA_HI);
                K_HIT:   act = 16'(bus.RD_HIT);
                K_DATA:  act = 16'(bus.RD_DATA);
                K_BUSY:  act = 16'(BUSY);
                K_SCK:   act = 16'(SCK);
                K_MOSI:  act = 16'(MOSI);
                K_SSN:   act = 16'(SS_N);
                K_DONE:  act = 16'(DONE);
                default: act = 'x;
            endcase
            n_checks++;
            if (c.cyc != cyc || act !== c.exp) begin
                n_fail++;
                $display("FAIL %s cyc=%0d got=%h want=%h", c.name, cyc, act, c.exp);
            end
        end
    end

    // Reference model: registers plus the start cycle of the last accepted transfer.
    logic [1:0]     m_bank;
    logic           m_nzp;
    logic [B0-1:0]  m_b0r, m_b0w;
    logic [NSS-1:0] m_ssn;
    logic           m_sclk, m_sck, m_mosi, m_ovr, m_pending;
    logic [7:0]     m_rx, m_tx;
    int             m_s;

    function automatic void model_reset();
        m_bank = 2'b00; m_nzp = 1'b1; m_b0r = '0; m_b0w = '0; m_ssn = '1;
        m_sclk = 1'b0; m_sck = 1'b0; m_mosi = 1'b0; m_ovr = 1'b0;
        m_rx = 8'h00; m_tx = 8'h00; m_pending = 1'b0; m_s = -1000;
    endfunction

    function automatic logic in_xfer(input int k);
        return (k >= m_s + 1) && (k <= m_s + T);
    endfunction

    function automatic void settle(input int k);
        if (m_pending && k >= m_s + T + 1) begin
            m_pending = 1'b0;
            m_mosi    = m_tx[0];
            m_sck     = 1'b0;
            m_rx      = m_tx;
        end
    endfunction

    function automatic void push(input int k, input kind_t kd, input logic [15:0] e,
                                 input string tag, input string nm);
        chk_t c;
        c.cyc = k; c.kind = kd; c.exp = e; c.name = {tag, ":", nm};
        exp_q.push_back(c);
    endfunction

    task automatic step(input logic v, input logic [15:0] a, input logic [15:0] ga,
                        input logic ngoe, input logic rst, input string tag);
        int          k;
        logic [1:0]  xin;
        logic        zpwin, en, busy, mosi, sck, hit;
        logic [7:0]  data;
        logic [15:0] rahi;
        int          idx;
        k    = cyc;
        xin  = 2'($urandom);
        bus.CTRL_VALID = v; bus.CTRL_ADDR = a; bus.GA = ga; bus.NGOE = ngoe;
        XIN = xin; RESET = rst;

        settle(k);
        busy = in_xfer(k);
        if (busy) begin
            idx  = 7 - (k - m_s - 1) / (2 * DIV);
            mosi = m_tx[idx];
            sck  = 1'(((k - m_s - 1) / DIV) % 2);
        end else begin
            mosi = m_mosi;
            sck  = m_sck;
        end
        zpwin = !m_nzp && (ga[14:7] == 8'h01);
        en    = ga[15] ^ zpwin;
        if (!en)                rahi = 16'h0;
        else if (m_bank != 2'b00) rahi = 16'(m_bank);
        else if (!ngoe)         rahi = 16'(m_b0r);
        else                    rahi = 16'(m_b0w);
        hit  = m_sclk && (ga == 16'h0000 || ga == 16'h0080 || ga == 16'h0081);
        data = 8'h00;
        if (hit && ga == 16'h0000) data = {m_bank, 1'b0, xin, busy, m_ovr, mosi};
        if (hit && ga == 16'h0080) data = {4'(m_b0w), 4'(m_b0r)};
        if (hit && ga == 16'h0081) data = m_rx;

        push(k, K_RAHI, rahi, tag, "ra_hi");
        push(k, K_HIT,  16'(hit), tag, "rd_hit");
        push(k, K_DATA, 16'(data), tag, "rd_data");
        push(k, K_BUSY, 16'(busy), tag, "busy");
        push(k, K_SCK,  16'(sck), tag, "sck");
        push(k, K_MOSI, 16'(mosi), tag, "mosi");
        push(k, K_SSN,  16'(m_ssn), tag, "ss_n");
        push(k, K_DONE, 16'(k == m_s + T + 1), tag, "done");

        if (rst) begin
            model_reset();
        end else begin
            if (hit && ga == 16'h0081) m_ovr = 1'b0;
            if (v) begin
                if (a[1:0] == 2'b11) begin m_b0r = '0; m_b0w = '0; end
                if (a[3:2] != 2'b00) begin
                    m_bank = a[7:6];
`ifdef CTRL_ZPBANK_EN
                    m_nzp = a[5];
`endif
                    m_ssn[1:0] = a[3:2];
                    m_sclk = a[0];
                    if (!busy) begin
                        m_mosi = a[15];
                        m_sck  = a[0] ~^ a[4];
                    end
                end else if (a[7:4] == 4'hF) begin
                    m_b0r = a[8 +: B0];
                    m_b0w = a[12 +: B0];
                end else if (a[7:4] == 4'hD) begin
                    m_ssn = a[8 +: NSS];
                end else if (a[7:4] == 4'hE) begin
                    if (k >= m_s + 1 && k <= m_s + T + 1) begin
                        m_ovr = 1'b1;
                    end else begin
                        m_s = k; m_tx = a[15:8]; m_pending = 1'b1;
                    end
                end
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n, input logic [15:0] ga, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, ga, 1'b0, 1'b0, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $finish;
    end

    initial begin
        logic [15:0] a, ga;
        RESET = 1'b1;
        bus.CTRL_VALID = 1'b0; bus.CTRL_ADDR = '0; bus.GA = '0; bus.NGOE = 1'b1; XIN = '0;
        repeat (2) @(posedge CLK);
        #1;
        model_reset();

        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, "reset");
        step(1'b1, 16'h00F0, 16'h1234, 1'b0, 1'b0, "c00F0");
        step(1'b1, 16'h21F0, 16'h8000, 1'b0, 1'b0, "c21F0");
        step(1'b0, 16'h0000, 16'h8000, 1'b0, 1'b0, "rahi_r");
        step(1'b0, 16'h0000, 16'h8000, 1'b1, 1'b0, "rahi_w");
        step(1'b1, 16'h804D, 16'h8000, 1'b0, 1'b0, "c804D");
        step(1'b0, 16'h0000, 16'h8000, 1'b0, 1'b0, "bank1");
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, "stat");
        step(1'b0, 16'h0000, 16'h0080, 1'b0, 1'b0, "b0rd");

        step(1'b1, 16'hA5E0, 16'h0000, 1'b0, 1'b0, "xA5");
        idx_loop: for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 16'h0000, 1'b0, 1'b0, "xA5run");
        step(1'b1, 16'h3CE0, 16'h0000, 1'b0, 1'b0, "ovr_start");
        step(1'b1, 16'h80FD, 16'h0000, 1'b0, 1'b0, "bb_busy");
        idle(T, 16'h0000, "xA5tail");
        step(1'b0, 16'h0000, 16'h0081, 1'b0, 1'b0, "rx_rd");
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, "ovr_clr");

        step(1'b1, 16'h5AE0, 16'h0000, 1'b0, 1'b0, "x5A");
        idle(7, 16'h0000, "x5Arun");
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, "rst_mid");
        idle(T + 2, 16'h0000, "post_rst");

        step(1'b1, 16'h21F0, 16'h0000, 1'b0, 1'b0, "zp_b0");
        step(1'b1, 16'h0009, 16'h0000, 1'b0, 1'b0, "c0009");
        step(1'b0, 16'h0000, 16'h0080, 1'b0, 1'b0, "zp0080r");
        step(1'b0, 16'h0000, 16'h00C3, 1'b1, 1'b0, "zp00C3w");
        step(1'b0, 16'h0000, 16'h8080, 1'b0, 1'b0, "zp8080");
        step(1'b0, 16'h0000, 16'h8000, 1'b0, 1'b0, "zp8000");

        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(3))
                0: begin
                    a = 16'($urandom);
                    if (a[3:2] == 2'b00) a[2] = 1'b1;
                end
                1: a = {8'($urandom), 4'hE, 2'b00, 2'($urandom)};
                2: a = {8'($urandom), 4'hF, 2'b00, 2'($urandom)};
                default: a = {8'($urandom), 4'($urandom), 2'b00, 2'($urandom)};
            endcase
            case ($urandom_range(5))
                0: ga = 16'h0000;
                1: ga = 16'h0080;
                2: ga = 16'h0081;
                3: ga = {1'b1, 15'($urandom)};
                4: ga = {1'($urandom), 8'h01, 7'($urandom)};
                default: ga = 16'($urandom);
            endcase
            step(($urandom_range(2) == 0), a, ga, 1'($urandom),
                 ($urandom_range(199) == 0), "rnd");
        end
        idle(T + 2, 16'h0081, "drain");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
        #1;
        if (exp_q.size() > 0) begin
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        end else begin
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        end
        $finish;
    end
endmodule
